// File: rtl/ring_entropy_collector.sv
// Ring-oscillator entropy collector: synchronised oscillator bus XOR-mixed into a Fibonacci
// shift register, with warm-up, repetition-count health test and valid/ready word packing.
module ring_entropy_collector #(
    parameter int unsigned      WIDTH     = 64,
    parameter int unsigned      OUT_W     = 32,
    parameter logic [WIDTH-1:0] TAPS      = 64'hD800_0000_0000_0000,
    parameter logic [WIDTH-1:0] SEED      = 64'hACE1_2468_BACE_1357,
    parameter int unsigned      WARMUP    = 256,
    parameter int unsigned      REP_LIMIT = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] osc_in_i,
    input  logic             seed_load_i,
    input  logic [WIDTH-1:0] seed_val_i,
    output logic             bit_out_o,
    output logic [OUT_W-1:0] rnd_data_o,
    output logic             rnd_valid_o,
    input  logic             rnd_ready_i,
    output logic             warm_o,
    output logic             health_err_o
);

    localparam int unsigned WCW = $clog2(WARMUP + 1);
    localparam int unsigned CW  = $clog2(OUT_W + 1);
    localparam int unsigned RW  = $clog2(REP_LIMIT + 1);

    localparam logic [1:0] ST_WARMUP  = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_STALL   = 2'd2;

    logic [WIDTH-1:0] osc_s1_q, osc_s2_q;
    logic [WIDTH-1:0] q_q, q_d;
    logic [1:0]       state_q, state_d;
    logic [WCW-1:0]   warm_cnt_q, warm_cnt_d;
    logic [CW-1:0]    count_q, count_d;
    logic [OUT_W-1:0] coll_q, coll_d;
    logic [RW-1:0]    rep_q, rep_d;
    logic             warm_q, warm_d;
    logic             health_q, health_d;
    logic [OUT_W-1:0] rnd_data_q, rnd_data_d;
    logic             rnd_valid_q, rnd_valid_d;

    logic             fb;
    logic [WIDTH-1:0] q_nxt, q_shift;
    logic             new_bit;
    logic             slot_free;

    always_comb begin
        fb        = ^(q_q & TAPS);
        q_nxt     = {q_q[WIDTH-2:0], fb} ^ osc_s2_q;
        // An all-zero register would lock up the LFSR; fall back to the seed.
        q_shift   = (q_nxt == '0) ? SEED : q_nxt;
        new_bit   = q_shift[WIDTH-1];
        slot_free = !rnd_valid_q || rnd_ready_i;

        q_d         = q_q;
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        count_d     = count_q;
        coll_d      = coll_q;
        rep_d       = rep_q;
        warm_d      = warm_q;
        health_d    = health_q;
        rnd_data_d  = rnd_data_q;
        rnd_valid_d = rnd_valid_q;

        if (rnd_valid_q && rnd_ready_i) begin
            rnd_valid_d = 1'b0;
        end

        if (seed_load_i) begin
            q_d        = (seed_val_i == '0) ? SEED : seed_val_i;
            warm_cnt_d = '0;
            count_d    = '0;
            coll_d     = '0;
            rep_d      = '0;
            health_d   = 1'b0;
            warm_d     = 1'b0;
            state_d    = ST_WARMUP;
        end else begin
            if (en_i) begin
                q_d = q_shift;
                if (new_bit == q_q[WIDTH-1]) begin
                    if (rep_q != RW'(REP_LIMIT)) rep_d = rep_q + 1'b1;
                end else begin
                    rep_d = RW'(1);
                end
                if (rep_d == RW'(REP_LIMIT)) health_d = 1'b1;
            end

            case (state_q)
                ST_WARMUP: begin
                    if (en_i) begin
                        if (warm_cnt_q == WCW'(WARMUP - 1)) begin
                            warm_d  = 1'b1;
                            state_d = ST_COLLECT;
                        end else begin
                            warm_cnt_d = warm_cnt_q + 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (en_i) begin
                        coll_d = {coll_q[OUT_W-2:0], new_bit};
                        if (count_q == CW'(OUT_W - 1)) begin
                            if (slot_free && !health_q) begin
                                rnd_data_d  = {coll_q[OUT_W-2:0], new_bit};
                                rnd_valid_d = 1'b1;
                                count_d     = '0;
                            end else begin
                                count_d = CW'(OUT_W);
                                state_d = ST_STALL;
                            end
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                ST_STALL: begin
                    // Held word moves out as soon as the slot frees, independent of en.
                    if (slot_free && !health_q) begin
                        rnd_data_d  = coll_q;
                        rnd_valid_d = 1'b1;
                        count_d     = '0;
                        state_d     = ST_COLLECT;
                    end
                end
                default: state_d = ST_WARMUP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            osc_s1_q    <= '0;
            osc_s2_q    <= '0;
            q_q         <= SEED;
            state_q     <= ST_WARMUP;
            warm_cnt_q  <= '0;
            count_q     <= '0;
            coll_q      <= '0;
            rep_q       <= '0;
            warm_q      <= 1'b0;
            health_q    <= 1'b0;
            rnd_data_q  <= '0;
            rnd_valid_q <= 1'b0;
        end else begin
            osc_s1_q    <= osc_in_i;
            osc_s2_q    <= osc_s1_q;
            q_q         <= q_d;
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            count_q     <= count_d;
            coll_q      <= coll_d;
            rep_q       <= rep_d;
            warm_q      <= warm_d;
            health_q    <= health_d;
            rnd_data_q  <= rnd_data_d;
            rnd_valid_q <= rnd_valid_d;
        end
    end

    assign bit_out_o    = q_q[WIDTH-1];
    assign rnd_data_o   = rnd_data_q;
    assign rnd_valid_o  = rnd_valid_q;
    assign warm_o       = warm_q;
    assign health_err_o = health_q;

endmodule

// File: tb/tb_ring_entropy_collector.sv
// Directed bench for ring_entropy_collector (WIDTH=64, OUT_W=8, WARMUP=16, REP_LIMIT=48).
module tb_ring_entropy_collector;

    localparam logic [63:0] TAPS_P = 64'hD800_0000_0000_0000;
    localparam logic [63:0] SEED_P = 64'hACE1_2468_BACE_1357;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [63:0] osc_in;
    logic        seed_load;
    logic [63:0] seed_val;
    logic        bit_out;
    logic [7:0]  rnd_data;
    logic        rnd_valid;
    logic        rnd_ready;
    logic        warm;
    logic        health_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] mq;
    logic [7:0]  mw;
    logic [7:0]  held;

    ring_entropy_collector #(
        .WIDTH    (64),
        .OUT_W    (8),
        .TAPS     (TAPS_P),
        .SEED     (SEED_P),
        .WARMUP   (16),
        .REP_LIMIT(48)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .osc_in_i    (osc_in),
        .seed_load_i (seed_load),
        .seed_val_i  (seed_val),
        .bit_out_o   (bit_out),
        .rnd_data_o  (rnd_data),
        .rnd_valid_o (rnd_valid),
        .rnd_ready_i (rnd_ready),
        .warm_o      (warm),
        .health_err_o(health_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] lfsr_step(input logic [63:0] q);
        logic [63:0] n;
        n = {q[62:0], ^(q & TAPS_P)};
        if (n == 64'h0) n = SEED_P;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One enabled edge with osc_in at zero; the model tracks the expected stream.
    task automatic adv();
        tick();
        mq = lfsr_step(mq);
        mw = {mw[6:0], mq[63]};
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; osc_in = '0; seed_load = 1'b0; seed_val = '0; rnd_ready = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({bit_out, rnd_data, rnd_valid, warm, health_err} !== {1'b1, 8'h00, 3'b000}) begin
            n_fail++;
            $display("FAIL reset: got bit=%b data=%h v=%b warm=%b err=%b, want 1 00 0 0 0",
                     bit_out, rnd_data, rnd_valid, warm, health_err);
        end
        rst = 1'b0;
        en  = 1'b1;
        mq  = SEED_P;
        mw  = '0;
    endtask

    task automatic test_first_word();
        logic ok;
        ok = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            adv();
            if (bit_out !== mq[63]) ok = 1'b0;
        end
        n_tests++;
        if (ok !== 1'b1 || warm !== 1'b0) begin
            n_fail++;
            $display("FAIL warmup15: got stream_ok=%b warm=%b, want 1 0", ok, warm);
        end
        adv();
        n_tests++;
        if (warm !== 1'b1) begin
            n_fail++; $display("FAIL warm16: got %b, want 1", warm);
        end
        repeat (7) adv();
        n_tests++;
        if (rnd_valid !== 1'b0) begin
            n_fail++; $display("FAIL valid23: got %b, want 0", rnd_valid);
        end
        adv();
        n_tests++;
        if (rnd_valid !== 1'b1 || rnd_data !== 8'h48 || mw !== 8'h48) begin
            n_fail++;
            $display("FAIL word24: got v=%b data=%h, want 1 48", rnd_valid, rnd_data);
        end
    endtask

    task automatic test_stall();
        logic ok;
        ok = 1'b1;
        rnd_ready = 1'b0;
        for (int k = 25; k <= 64; k++) begin
            adv();
            if (rnd_valid !== 1'b1 || rnd_data !== 8'h48) ok = 1'b0;
        end
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL stall_hold: got ok=%b data=%h, want 1 48", ok, rnd_data);
        end
        rnd_ready = 1'b1;
        adv();
        n_tests++;
        if (rnd_valid !== 1'b1 || rnd_data !== 8'hD1) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b data=%h, want 1 d1", rnd_valid, rnd_data);
        end
        ok = 1'b1;
        for (int k = 66; k <= 72; k++) begin
            adv();
            if (rnd_valid !== 1'b0) ok = 1'b0;
        end
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL gap66_72: got ok=%b, want 1", ok);
        end
        adv();
        n_tests++;
        if (rnd_valid !== 1'b1 || rnd_data !== mw) begin
            n_fail++; $display("FAIL word73: got v=%b data=%h, want 1 %h", rnd_valid, rnd_data, mw);
        end
        repeat (8) adv();
        n_tests++;
        if (rnd_valid !== 1'b1 || rnd_data !== mw) begin
            n_fail++; $display("FAIL word81: got v=%b data=%h, want 1 %h", rnd_valid, rnd_data, mw);
        end
    endtask

    task automatic test_seed_load();
        logic ok;
        logic b;
        adv();
        rnd_ready = 1'b0;
        repeat (7) adv();
        held = mw;
        n_tests++;
        if (rnd_valid !== 1'b1 || rnd_data !== held) begin
            n_fail++;
            $display("FAIL word89: got v=%b data=%h, want 1 %h", rnd_valid, rnd_data, held);
        end
        repeat (3) adv();
        seed_load = 1'b1; seed_val = '0;
        tick();
        seed_load = 1'b0;
        n_tests++;
        if ({warm, rnd_valid, rnd_data, bit_out} !== {1'b0, 1'b1, held, 1'b1}) begin
            n_fail++;
            $display("FAIL seed_load: got warm=%b v=%b data=%h bit=%b, want 0 1 %h 1",
                     warm, rnd_valid, rnd_data, bit_out, held);
        end
        rnd_ready = 1'b1;
        repeat (10) tick();
        en = 1'b0;
        b  = bit_out;
        ok = 1'b1;
        repeat (5) begin
            tick();
            if (bit_out !== b || warm !== 1'b0 || rnd_valid !== 1'b0) ok = 1'b0;
        end
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL en_hold: got ok=%b, want 1", ok);
        end
        en = 1'b1;
        repeat (5) tick();
        n_tests++;
        if (warm !== 1'b0) begin
            n_fail++; $display("FAIL reseed_warm15: got %b, want 0", warm);
        end
        tick();
        n_tests++;
        if (warm !== 1'b1) begin
            n_fail++; $display("FAIL reseed_warm16: got %b, want 1", warm);
        end
        repeat (7) tick();
        n_tests++;
        if (rnd_valid !== 1'b0) begin
            n_fail++; $display("FAIL reseed_valid23: got %b, want 0", rnd_valid);
        end
        tick();
        n_tests++;
        if (rnd_valid !== 1'b1 || rnd_data !== 8'h48) begin
            n_fail++;
            $display("FAIL reseed_word24: got v=%b data=%h, want 1 48", rnd_valid, rnd_data);
        end
    endtask

    task automatic test_zero_lock();
        logic [63:0] cap;
        en = 1'b0; osc_in = 64'h2;
        repeat (3) tick();
        seed_load = 1'b1; seed_val = 64'h1;
        tick();
        seed_load = 1'b0;
        n_tests++;
        if (bit_out !== 1'b0) begin
            n_fail++; $display("FAIL seed_one: got bit=%b, want 0", bit_out);
        end
        en = 1'b1;
        tick();
        en = 1'b0; osc_in = '0;
        repeat (3) tick();
        en = 1'b1;
        cap[63] = bit_out;
        for (int k = 1; k <= 63; k++) begin
            tick();
            cap[63-k] = bit_out;
        end
        en = 1'b0;
        n_tests++;
        if (cap !== SEED_P) begin
            n_fail++; $display("FAIL zero_lock: got %h, want %h", cap, SEED_P);
        end
    endtask

    task automatic test_health();
        logic ok;
        osc_in = 64'h1; rnd_ready = 1'b1;
        repeat (3) tick();
        seed_load = 1'b1; seed_val = '1;
        tick();
        seed_load = 1'b0;
        rnd_ready = 1'b0;
        n_tests++;
        if (rnd_valid !== 1'b0 || health_err !== 1'b0) begin
            n_fail++;
            $display("FAIL health_pre: got v=%b err=%b, want 0 0", rnd_valid, health_err);
        end
        en = 1'b1;
        repeat (47) tick();
        n_tests++;
        if (health_err !== 1'b0 || rnd_valid !== 1'b1 || rnd_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL health47: got err=%b v=%b data=%h, want 0 1 ff",
                     health_err, rnd_valid, rnd_data);
        end
        tick();
        n_tests++;
        if (health_err !== 1'b1) begin
            n_fail++; $display("FAIL health48: got %b, want 1", health_err);
        end
        rnd_ready = 1'b1;
        ok = 1'b1;
        repeat (12) begin
            tick();
            if (rnd_valid !== 1'b0 || health_err !== 1'b1) ok = 1'b0;
        end
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL health_block: got ok=%b, want 1", ok);
        end
        en = 1'b0; osc_in = '0;
        repeat (3) tick();
        seed_load = 1'b1; seed_val = '0;
        tick();
        seed_load = 1'b0;
        n_tests++;
        if (health_err !== 1'b0 || warm !== 1'b0) begin
            n_fail++;
            $display("FAIL health_clear: got err=%b warm=%b, want 0 0", health_err, warm);
        end
    endtask

    task automatic test_async_reset();
        rnd_ready = 1'b0;
        en = 1'b1;
        repeat (37) tick();
        n_tests++;
        if ({rnd_valid, rnd_data, warm, bit_out} !== {1'b1, 8'h48, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_pre_rst: got v=%b data=%h warm=%b bit=%b, want 1 48 1 0",
                     rnd_valid, rnd_data, warm, bit_out);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({bit_out, rnd_data, rnd_valid, warm, health_err} !== {1'b1, 8'h00, 3'b000}) begin
            n_fail++;
            $display("FAIL async_rst: got bit=%b data=%h v=%b warm=%b err=%b, want 1 00 0 0 0",
                     bit_out, rnd_data, rnd_valid, warm, health_err);
        end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_stall();
        test_seed_load();
        test_zero_lock();
        test_health();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_entropy_collector.md
# ring_entropy_collector

Parametrised successor to the 64-bit ring-oscillator mixing LFSR. It synchronises WIDTH raw oscillator lines and XOR-mixes them into a configurable-tap Fibonacci shift register. It then enforces a warm-up period, runs a repetition-count health test on the serial output, and packs output bits into OUT_W-bit words behind a valid/ready handshake. It sits between the ring-oscillator bank and the TRNG output FIFO / AXI register slice.

## Interface
- WIDTH, 64, shift-register and oscillator-bus width (≥ 8)
- OUT_W, 32, output word width (2 ≤ OUT_W ≤ WIDTH)
- TAPS, 64'hD800_0000_0000_0000, feedback tap mask; default taps are bits 63, 62, 60, 59
- SEED, 64'hACE1_2468_BACE_1357, reset and fallback state (must be nonzero)
- WARMUP, 256, enabled shifts discarded after reset or reseed (≥ 1)
- REP_LIMIT, 48, consecutive identical bit_out samples that trip the health error (≥ 2)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  shift enable; when low, all state holds
- osc_in  in  WIDTH  raw asynchronous oscillator outputs
- seed_load  in  1  single-cycle pulse; loads seed_val and restarts warm-up
- seed_val  in  WIDTH  reseed value; zero selects SEED
- bit_out  out  1  q_reg[WIDTH-1]
- rnd_data  out  OUT_W  packed output word
- rnd_valid  out  1  rnd_data holds an unconsumed word
- rnd_ready  in  1  consumer accepts the word
- warm  out  1  warm-up complete
- health_err  out  1  sticky repetition-test failure

## Operation
- Synchroniser: osc_s is osc_in passed through two flops; both flops reset to 0.
- Feedback: fb = ^(q_reg & TAPS).
- Next state: q_next[0] = fb ^ osc_s[0]; q_next[i] = q_reg[i-1] ^ osc_s[i].
- Zero lock: if q_next is all zero, q_reg loads SEED instead.
- Priority, highest first:
  - rst
  - seed_load: q_reg <= (seed_val==0 ? SEED : seed_val); warm-up counter, collector count and repetition counter clear; health_err clears; FSM goes to WARMUP; rnd_valid/rnd_data are untouched.
  - en: q_reg <= q_next.
- FSM states: WARMUP, COLLECT, STALL.
  - WARMUP: counts enabled shifts. On the WARMUP-th shift, warm <= 1 and the FSM moves to COLLECT.
  - COLLECT: each enabled shift appends the new q_next[WIDTH-1] at the collector LSB (MSB-first packing) and increments the count.
    - On the shift that supplies bit OUT_W, if the slot is free (!rnd_valid || rnd_ready) and !health_err: rnd_data <= {collector[OUT_W-2:0], new bit}, rnd_valid <= 1, count <= 0, stay in COLLECT.
    - Otherwise the collector is full and the FSM moves to STALL.
  - STALL: the LFSR keeps shifting when en; new bits are discarded. When the slot frees and !health_err, transfer the held word and return to COLLECT with count 0. The transfer does not require en.
- Handshake:
  - The word is consumed on a cycle where rnd_valid && rnd_ready.
  - rnd_valid drops the next cycle unless a transfer reloads it in that same cycle, allowing back-to-back words.
  - rnd_data is stable while rnd_valid && !rnd_ready.
- Health test: each enabled shift compares the new bit_out with the previous one. Equal increments the run counter; different resets it to 1. Reaching REP_LIMIT sets health_err.
  - health_err blocks new transfers.
  - A pending rnd_valid word still drains.
  - health_err clears only on rst or seed_load.
- warm clears on seed_load.

## Timing
- Reset values:
  - q_reg = SEED; bit_out = SEED[WIDTH-1]
  - rnd_data = 0, rnd_valid = 0, warm = 0, health_err = 0
  - counters = 0; FSM = WARMUP
- osc_in to q_reg influence: 3 edges (2 synchroniser + 1 register).
- First rnd_valid rises after the (WARMUP+OUT_W)-th enabled edge following reset/seed_load, when no stall or health error occurs.
- Sustained throughput: one word per OUT_W enabled cycles.
- en low: counters, FSM and q_reg freeze; handshake and STALL transfer still operate.
- A seed_load that coincides with the OUT_W-th bit wins: no transfer, and the collector clears.

## Test plan
- Reset release, osc_in=0, en=1, WARMUP=16, OUT_W=8: q_reg follows the pure LFSR from SEED; warm rises after edge 16; rnd_valid rises after edge 24; rnd_data equals the 8 LFSR output bits 17..24, MSB-first (compare against the reference model).
- rnd_ready held 0 for 40 cycles after the first word: rnd_data is stable, FSM reaches STALL, and LFSR bits are discarded. Raising rnd_ready makes the held word appear the next cycle; then one word per 8 cycles.
- seed_load with seed_val=0 mid-COLLECT: q_reg = SEED, warm = 0, collector cleared, pending rnd_valid word unaffected; new data starts after 16+8 edges.
- Force q_reg to a state where q_next is all zero (seed_val=64'h1, TAPS with that feedback zero, osc_s[1]=1): q_reg loads SEED, never 0.
- osc_in driven so that bit_out stays 1 for REP_LIMIT=48 shifts: health_err sets on the 48th equal sample; no further rnd_valid; seed_load clears it.
- rst asserted asynchronously while rnd_valid=1 in STALL: all outputs return to their reset values immediately.
